uart_mmio_bridge: RTL and testbench

- Bus-side front end for the byte-level `uart` core.
- Presents a 4-register memory-mapped interface to the CPU bus.
- Buffers outgoing bytes in a TX FIFO and feeds them to the core's `we`/`data_in` handshake.
- Captures completed receive bytes from the core's `rx_busy`/`data_out` into an RX FIFO; raises a level interrupt.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_mmio_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART memory-mapped bridge.
//   - register offsets on the 2-bit bus address
//   - bit positions inside the STATUS and CTRL registers
//   - TX handshake state encoding
package uart_pkg;

    // Register offsets
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    // STATUS bit positions
    localparam int unsigned ST_RX_EMPTY    = 0;
    localparam int unsigned ST_RX_FULL     = 1;
    localparam int unsigned ST_TX_EMPTY    = 2;
    localparam int unsigned ST_TX_FULL     = 3;
    localparam int unsigned ST_RX_OVERRUN  = 4;
    localparam int unsigned ST_TX_OVERFLOW = 5;
    localparam int unsigned ST_TX_ACTIVE   = 6;

    // CTRL bit positions
    localparam int unsigned CT_RX_IRQ_EN = 0;
    localparam int unsigned CT_TX_IRQ_EN = 1;
    localparam int unsigned CT_LOOPBACK  = 2;

    // TX handshake states
    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_WAIT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head output.
//   clk, rst    : clock, asynchronous active-high reset
//   push, din   : write request and data (accepted when not full, or when
//                 a pop happens in the same cycle)
//   pop, dout   : read request (ignored when empty) and current head
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: CPU-bus front end for the byte-level uart core.
//   Four registers (DATA, STATUS, CTRL, LEVEL), a TX FIFO drained into the
//   core's we/data_in handshake, an RX FIFO filled from completed core
//   receptions, and a registered level interrupt.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   bus_cs, bus_we, bus_addr : one-cycle register access strobe, direction, index
//   bus_wdata / bus_rdata    : write data / registered read data (1-cycle latency)
//   irq                      : level interrupt
//   core_we, core_data_in    : TX handshake to the core
//   core_tx_busy             : core transmitter busy
//   core_rx_busy, core_data_out : core receiver busy and received byte
// Build option: define UART_MMIO_LOOPBACK_EN to enable CTRL bit2 internal
// loopback (TX FIFO head moved straight into the RX FIFO).
module uart_mmio_bridge
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_cs,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic        core_we,
    output logic [7:0]  core_data_in,
    input  logic        core_tx_busy,
    input  logic        core_rx_busy,
    input  logic [7:0]  core_data_out
);

    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);

    // Bus decode
    logic rd_req;
    logic wr_req;
    assign rd_req = bus_cs & ~bus_we;
    assign wr_req = bus_cs & bus_we;

    // FIFO wiring
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]       tx_dout;
    logic [FIFO_AW:0] tx_count;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       rx_din, rx_dout;
    logic [FIFO_AW:0] rx_count;

    // Control / status state
    tx_state_t state;
    logic      ctrl_rx_irq_en;
    logic      ctrl_tx_irq_en;
    logic      rx_overrun;
    logic      tx_overflow;
    logic      rx_busy_q;
    logic      cap_pend;
    logic      loop_on;
    logic      loop_move;
    logic      fsm_pop;

`ifdef UART_MMIO_LOOPBACK_EN
    logic ctrl_loopback;
    assign loop_on   = ctrl_loopback;
    assign loop_move = ctrl_loopback & ~tx_empty & ~rx_full;
`else
    assign loop_on   = 1'b0;
    assign loop_move = 1'b0;
`endif

    // A new byte is only offered while the core is idle: if busy were still
    // high, T_REQ would take it as the acceptance of the new byte.
    assign fsm_pop = (state == T_IDLE) & ~tx_empty & ~core_tx_busy & ~loop_on;

    assign tx_push = wr_req & (bus_addr == REG_DATA);
    assign tx_pop  = fsm_pop | loop_move;
    assign rx_pop  = rd_req & (bus_addr == REG_DATA);
    assign rx_push = loop_on ? loop_move : cap_pend;
    assign rx_din  = loop_on ? tx_dout   : core_data_out;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (bus_wdata[7:0]),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_din),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // TX handshake FSM. core_we stays high through T_REQ because the core
    // only samples it on oversample ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= T_IDLE;
            core_we      <= 1'b0;
            core_data_in <= '0;
        end else begin
            case (state)
                T_IDLE: begin
                    if (fsm_pop) begin
                        core_data_in <= tx_dout;
                        core_we      <= 1'b1;
                        state        <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (core_tx_busy) begin
                        core_we <= 1'b0;
                        state   <= T_WAIT;
                    end
                end
                T_WAIT: begin
                    if (!core_tx_busy) begin
                        state <= T_IDLE;
                    end
                end
                default: begin
                    core_we <= 1'b0;
                    state   <= T_IDLE;
                end
            endcase
        end
    end

    // RX capture: the core refreshes data_out in its first idle cycle, so
    // the push happens one clk after the busy falling edge is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_busy_q <= 1'b0;
            cap_pend  <= 1'b0;
        end else begin
            rx_busy_q <= core_rx_busy;
            cap_pend  <= rx_busy_q & ~core_rx_busy & ~loop_on;
        end
    end

    // CTRL register and sticky error flags (a new error wins over a clear
    // arriving in the same cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_rx_irq_en <= 1'b0;
            ctrl_tx_irq_en <= 1'b0;
`ifdef UART_MMIO_LOOPBACK_EN
            ctrl_loopback  <= 1'b0;
`endif
            rx_overrun     <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            if (wr_req && bus_addr == REG_CTRL) begin
                ctrl_rx_irq_en <= bus_wdata[CT_RX_IRQ_EN];
                ctrl_tx_irq_en <= bus_wdata[CT_TX_IRQ_EN];
`ifdef UART_MMIO_LOOPBACK_EN
                ctrl_loopback  <= bus_wdata[CT_LOOPBACK];
`endif
            end
            if (wr_req && bus_addr == REG_STATUS) begin
                if (bus_wdata[ST_RX_OVERRUN])  rx_overrun  <= 1'b0;
                if (bus_wdata[ST_TX_OVERFLOW]) tx_overflow <= 1'b0;
            end
            if (rx_push && rx_full && !rx_pop) rx_overrun  <= 1'b1;
            if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
        end
    end

    // Read mux
    logic [31:0] rdata_next;
    always_comb begin
        rdata_next = '0;
        case (bus_addr)
            REG_DATA: begin
                if (!rx_empty) rdata_next = {23'b0, 1'b1, rx_dout};
            end
            REG_STATUS: begin
                rdata_next[ST_RX_EMPTY]    = rx_empty;
                rdata_next[ST_RX_FULL]     = rx_full;
                rdata_next[ST_TX_EMPTY]    = tx_empty;
                rdata_next[ST_TX_FULL]     = tx_full;
                rdata_next[ST_RX_OVERRUN]  = rx_overrun;
                rdata_next[ST_TX_OVERFLOW] = tx_overflow;
                rdata_next[ST_TX_ACTIVE]   = (state != T_IDLE) | core_tx_busy;
            end
            REG_CTRL: begin
                rdata_next[CT_RX_IRQ_EN] = ctrl_rx_irq_en;
                rdata_next[CT_TX_IRQ_EN] = ctrl_tx_irq_en;
`ifdef UART_MMIO_LOOPBACK_EN
                rdata_next[CT_LOOPBACK]  = ctrl_loopback;
`endif
            end
            REG_LEVEL: begin
                rdata_next[FIFO_AW:0]     = rx_count;
                rdata_next[FIFO_AW+8:8]   = tx_count;
            end
            default: rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            if (rd_req) bus_rdata <= rdata_next;
            irq <= (ctrl_rx_irq_en & ~rx_empty) |
                   (ctrl_tx_irq_en & tx_empty & (state == T_IDLE));
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^bus_wdata[31:8];

endmodule

// File: tb/tb_uart_mmio_bridge.sv
module tb_uart_mmio_bridge;

    logic        clk;
    logic        rst;
    logic        bus_cs;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;
    logic        core_we;
    logic [7:0]  core_data_in;
    logic        core_tx_busy;
    logic        core_rx_busy;
    logic [7:0]  core_data_out;

    int n_checks;
    int n_fail;

    uart_mmio_bridge #(.FIFO_DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus_cs        (bus_cs),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .irq           (irq),
        .core_we       (core_we),
        .core_data_in  (core_data_in),
        .core_tx_busy  (core_tx_busy),
        .core_rx_busy  (core_rx_busy),
        .core_data_out (core_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus and core stimulus helpers; all drive at posedge+1 and return at posedge+1.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_cs = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_cs = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(posedge clk); #1;
        bus_cs = 1'b0;
        d = bus_rdata;
    endtask

    // Core reception: busy high, busy falls with junk on data_out, real byte
    // appears one cycle later; optionally a DATA read lands on the push cycle.
    task automatic rx_capture(input logic [7:0] b, input logic rd_at_push);
        core_rx_busy = 1'b1;
        @(posedge clk); #1;
        core_data_out = 8'hEE; core_rx_busy = 1'b0;
        @(posedge clk); #1;
        core_data_out = b;
        if (rd_at_push) begin
            bus_cs = 1'b1; bus_we = 1'b0; bus_addr = 2'd0;
        end
        @(posedge clk); #1;
        bus_cs = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = '0;
        core_tx_busy = 1'b0; core_rx_busy = 1'b0; core_data_out = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = '0;
        core_tx_busy = 1'b0; core_rx_busy = 1'b0; core_data_out = 8'h00;
        #1;
        n_checks++;
        if (bus_rdata !== 32'h0 || irq !== 1'b0 || core_we !== 1'b0 || core_data_in !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: rdata=%h irq=%b we=%b din=%h, required 0/0/0/0",
                     bus_rdata, irq, core_we, core_data_in);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h05) begin n_fail++; $display("FAIL reset_status: got %h required %h", d, 32'h05); end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_level: got %h required %h", d, 32'h0); end
        bus_read(2'd2, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h required %h", d, 32'h0); end
    endtask

    task automatic test_tx_single();
        logic [31:0] d;
        do_reset();
        bus_write(2'd0, 32'h41);
        @(posedge clk); #1;
        n_checks++;
        if (core_we !== 1'b1 || core_data_in !== 8'h41) begin
            n_fail++; $display("FAIL tx_req: we=%b din=%h required 1/41", core_we, core_data_in);
        end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h45) begin n_fail++; $display("FAIL tx_status_req: got %h required %h", d, 32'h45); end
        @(posedge clk); #1;
        n_checks++;
        if (core_we !== 1'b1 || core_data_in !== 8'h41) begin
            n_fail++; $display("FAIL tx_req_held: we=%b din=%h required 1/41", core_we, core_data_in);
        end
        core_tx_busy = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (core_we !== 1'b0) begin n_fail++; $display("FAIL tx_we_drop: got %b required 0", core_we); end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h45) begin n_fail++; $display("FAIL tx_status_busy: got %h required %h", d, 32'h45); end
        core_tx_busy = 1'b0;
        @(posedge clk); #1;
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h05) begin n_fail++; $display("FAIL tx_status_done: got %h required %h", d, 32'h05); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        int          n;
        logic        stray;
        do_reset();
        core_tx_busy = 1'b1;
        for (int i = 0; i <= 16; i++) bus_write(2'd0, 32'(i));
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h1000) begin n_fail++; $display("FAIL ovf_level: got %h required %h", d, 32'h1000); end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h69) begin n_fail++; $display("FAIL ovf_status: got %h required %h", d, 32'h69); end
        core_tx_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            while (core_we !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
            n_checks++;
            if (n >= 20 || core_data_in !== 8'(i)) begin
                n_fail++;
                $display("FAIL ovf_send_%0d: we=%b din=%h waited=%0d required din %h", i, core_we, core_data_in, n, 8'(i));
            end
            core_tx_busy = 1'b1;
            @(posedge clk); #1;
            core_tx_busy = 1'b0;
        end
        stray = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (core_we) stray = 1'b1; end
        n_checks++;
        if (stray !== 1'b0) begin n_fail++; $display("FAIL ovf_lost_byte: extra core_we=%b required 0 (din=%h)", stray, core_data_in); end
        bus_write(2'd1, 32'h20);
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h05) begin n_fail++; $display("FAIL ovf_clear: got %h required %h", d, 32'h05); end
    endtask

    task automatic test_rx_single();
        logic [31:0] d;
        do_reset();
        rx_capture(8'h5A, 1'b0);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h15A) begin n_fail++; $display("FAIL rx_data: got %h required %h", d, 32'h15A); end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rx_empty_read: got %h required %h", d, 32'h0); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i <= 16; i++) rx_capture(8'(8'h80 + i), 1'b0);
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h16) begin n_fail++; $display("FAIL ovr_status: got %h required %h", d, 32'h16); end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h10) begin n_fail++; $display("FAIL ovr_level: got %h required %h", d, 32'h10); end
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, d);
            n_checks++;
            if (d !== 32'h180 + 32'(i)) begin
                n_fail++; $display("FAIL ovr_data_%0d: got %h required %h", i, d, 32'h180 + 32'(i));
            end
        end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL ovr_drained: got %h required %h", d, 32'h0); end
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h05) begin n_fail++; $display("FAIL ovr_clear: got %h required %h", d, 32'h05); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        do_reset();
        // Empty FIFO: read returns nothing, push still lands.
        rx_capture(8'hA5, 1'b1);
        n_checks++;
        if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL sc_empty_read: got %h required %h", bus_rdata, 32'h0); end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL sc_empty_level: got %h required %h", d, 32'h1); end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h1A5) begin n_fail++; $display("FAIL sc_empty_data: got %h required %h", d, 32'h1A5); end
        // Full FIFO: pop frees a slot for the push.
        for (int i = 0; i < 16; i++) rx_capture(8'(8'h80 + i), 1'b0);
        rx_capture(8'hC5, 1'b1);
        n_checks++;
        if (bus_rdata !== 32'h180) begin n_fail++; $display("FAIL sc_full_read: got %h required %h", bus_rdata, 32'h180); end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h10) begin n_fail++; $display("FAIL sc_full_level: got %h required %h", d, 32'h10); end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h06) begin n_fail++; $display("FAIL sc_full_status: got %h required %h", d, 32'h06); end
        for (int i = 1; i < 16; i++) begin
            bus_read(2'd0, d);
            n_checks++;
            if (d !== 32'h180 + 32'(i)) begin
                n_fail++; $display("FAIL sc_order_%0d: got %h required %h", i, d, 32'h180 + 32'(i));
            end
        end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h1C5) begin n_fail++; $display("FAIL sc_last: got %h required %h", d, 32'h1C5); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        do_reset();
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, d);
        n_checks++;
        if (d !== 32'h1 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_ctrl: ctrl=%h irq=%b required 1/0", d, irq); end
        rx_capture(8'h33, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag: got %b required 0", irq); end
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b required 1", irq); end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h133 || irq !== 1'b1) begin n_fail++; $display("FAIL irq_pop: data=%h irq=%b required 133/1", d, irq); end
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b required 0", irq); end
        bus_write(2'd2, 32'h2);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tx_lag: got %b required 0", irq); end
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_tx_rise: got %b required 1", irq); end
        bus_write(2'd2, 32'h0);
    endtask

`ifdef UART_MMIO_LOOPBACK_EN
    task automatic test_loopback();
        logic [31:0] d;
        logic        seen;
        do_reset();
        bus_write(2'd2, 32'h4);
        bus_write(2'd0, 32'h77);
        seen = 1'b0;
        repeat (3) begin if (core_we) seen = 1'b1; @(posedge clk); #1; end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL lb_core_we: got %b required 0", seen); end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h177) begin n_fail++; $display("FAIL lb_data: got %h required %h", d, 32'h177); end
        bus_read(2'd2, d);
        n_checks++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL lb_ctrl: got %h required %h", d, 32'h4); end
    endtask
`else
    task automatic test_ctrl_mask();
        logic [31:0] d;
        do_reset();
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, d);
        n_checks++;
        if (d !== 32'h3) begin n_fail++; $display("FAIL ctrl_mask: got %h required %h", d, 32'h3); end
        bus_write(2'd2, 32'h0);
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] d;
        do_reset();
        rx_capture(8'h12, 1'b0);
        bus_write(2'd0, 32'h99);
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h0101 || core_we !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: level=%h we=%b required 0101/1", d, core_we);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (core_we !== 1'b0 || bus_rdata !== 32'h0 || core_data_in !== 8'h00 || irq !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: we=%b rdata=%h din=%h irq=%b required 0/0/0/0",
                               core_we, bus_rdata, core_data_in, irq);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL mid_level: got %h required %h", d, 32'h0); end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h05) begin n_fail++; $display("FAIL mid_status: got %h required %h", d, 32'h05); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_tx_single();
        test_tx_overflow();
        test_rx_single();
        test_rx_overrun();
        test_same_cycle();
        test_irq();
`ifdef UART_MMIO_LOOPBACK_EN
        test_loopback();
`else
        test_ctrl_mask();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
